// File: rtl/simon_sequence_engine.sv
// Simon sequence engine: rewinds the game LFSR and replays its colour stream,
// either lighting the LEDs note by note or checking player presses against it.
module simon_sequence_engine #(
    parameter int ON_TICKS       = 3,
    parameter int OFF_TICKS      = 1,
    parameter int TIMEOUT_TICKS  = 20,
    parameter int STEPS_PER_NOTE = 2,
    parameter int LEN_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start_show,
    input  logic             start_check,
    input  logic [LEN_W-1:0] length,
    input  logic [1:0]       random_bits,
    input  logic             btn_valid,
    input  logic [1:0]       btn_color,
    output logic             lfsr_step,
    output logic             lfsr_rerun,
    output logic [3:0]       led,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail
);
    localparam int CNT_MAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CNT_MAX1 = (CNT_MAX0 > TIMEOUT_TICKS) ? CNT_MAX0 : TIMEOUT_TICKS;
    localparam int CNT_MAX  = (CNT_MAX1 > STEPS_PER_NOTE) ? CNT_MAX1 : STEPS_PER_NOTE;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, RERUN, LOAD, ON, OFF, WAIT, ADV} state_t;

    state_t           state;
    logic             mode_check;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [1:0]       colour;
    logic [CNT_W-1:0] cnt;
    logic             last_note;

    // len_q is at least 1 whenever this is consulted, so the subtraction never wraps
    assign last_note = (idx == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mode_check <= 1'b0;
            len_q      <= '0;
            idx        <= '0;
            colour     <= '0;
            cnt        <= '0;
            lfsr_step  <= 1'b0;
            lfsr_rerun <= 1'b0;
            led        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            lfsr_step  <= 1'b0;
            lfsr_rerun <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_show || start_check) begin
                        mode_check <= !start_show;
                        len_q      <= length;
                        idx        <= '0;
                        if (length == '0) begin
                            done <= start_show;
                            pass <= !start_show;
                        end else begin
                            state      <= RERUN;
                            lfsr_rerun <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                RERUN: state <= LOAD;
                LOAD: begin
                    colour <= random_bits;
                    cnt    <= '0;
                    if (mode_check) begin
                        state <= WAIT;
                    end else begin
                        state <= ON;
                        led   <= 4'b0001 << random_bits;
                    end
                end
                ON: begin
                    if (tick) begin
                        if (cnt == CNT_W'(ON_TICKS - 1)) begin
                            state <= OFF;
                            cnt   <= '0;
                            led   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                OFF: begin
                    if (tick) begin
                        if (cnt == CNT_W'(OFF_TICKS - 1)) begin
                            cnt <= '0;
                            if (last_note) begin
                                state <= IDLE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state     <= ADV;
                                lfsr_step <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    // a press in the same cycle as the timeout tick takes precedence
                    if (btn_valid) begin
                        if (btn_color != colour) begin
                            state <= IDLE;
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (last_note) begin
                            state <= IDLE;
                            pass  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= ADV;
                            lfsr_step <= 1'b1;
                            cnt       <= '0;
                        end
                    end else if (tick) begin
                        if (cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
                            state <= IDLE;
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ADV: begin
                    // lfsr_step was raised on entry; keep it up until STEPS_PER_NOTE cycles elapse
                    if (cnt == CNT_W'(STEPS_PER_NOTE - 1)) begin
                        state <= LOAD;
                        idx   <= idx + LEN_W'(1);
                        cnt   <= '0;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        lfsr_step <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simon_sequence_engine.sv
// Bench for simon_sequence_engine: a behavioural LFSR drives random_bits, and
// a note-level model predicts colours, step counts and outcomes.
module tb_simon_sequence_engine;
    localparam int ON_T = 3, OFF_T = 1, TO_T = 20, STEPS = 2, LEN_W = 5;

    logic clk = 1'b0, reset = 1'b1, tick = 1'b0, start_show = 1'b0, start_check = 1'b0;
    logic [LEN_W-1:0] length = '0;
    logic [1:0] random_bits;
    logic btn_valid = 1'b0;
    logic [1:0] btn_color = '0;
    logic lfsr_step, lfsr_rerun, busy, done, pass, fail;
    logic [3:0] led;

    simon_sequence_engine #(.ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .TIMEOUT_TICKS(TO_T),
                            .STEPS_PER_NOTE(STEPS), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start_show(start_show),
        .start_check(start_check), .length(length), .random_bits(random_bits),
        .btn_valid(btn_valid), .btn_color(btn_color), .lfsr_step(lfsr_step),
        .lfsr_rerun(lfsr_rerun), .led(led), .busy(busy), .done(done), .pass(pass), .fail(fail));

    always #5 clk = ~clk;

    logic [15:0] seed = 16'hACE1;
    logic [15:0] lfsr = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    always @(posedge clk)
        if (reset || lfsr_rerun) lfsr <= seed;
        else if (lfsr_step) lfsr <= lfsr_next(lfsr);
    assign random_bits = lfsr[1:0];

    // colour of note k: seed advanced k*STEPS times
    function automatic int colour_at(input int k);
        logic [15:0] s;
        s = seed;
        for (int i = 0; i < k * STEPS; i++) s = lfsr_next(s);
        return int'(s[1:0]);
    endfunction

    int n_chk = 0, n_ok = 0;
    int n_step, n_rerun, n_done, n_pass, n_fail, on_ticks, n_bad, cyc;
    int notes[$];
    logic [3:0] prev_led = '0;
    bit rand_tick = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clr_stats();
        n_step = 0; n_rerun = 0; n_done = 0; n_pass = 0; n_fail = 0;
        on_ticks = 0; n_bad = 0; cyc = 0; notes.delete();
    endtask

    task automatic clk1();
        if (rand_tick) tick = ($urandom_range(0, 2) != 0);
        if (tick && led != 4'd0) on_ticks++;
        @(posedge clk); #1;
        cyc++;
        n_step += int'(lfsr_step); n_rerun += int'(lfsr_rerun);
        n_done += int'(done); n_pass += int'(pass); n_fail += int'(fail);
        if (lfsr_step && lfsr_rerun) n_bad++;
        if ($countones(led) > 1) n_bad++;
        if (int'(done) + int'(pass) + int'(fail) > 1) n_bad++;
        if ((done || pass || fail) && busy) n_bad++;
        if (led != 4'd0 && prev_led == 4'd0) notes.push_back($clog2(led));
        prev_led = led;
    endtask

    task automatic do_reset();
        reset = 1'b1; clk1(); clk1(); reset = 1'b0; clr_stats();
    endtask

    task automatic start(input bit show, input bit chk, input int len);
        clr_stats();
        start_show = show; start_check = chk; length = LEN_W'(len);
        clk1();
        start_show = 1'b0; start_check = 1'b0;
    endtask

    task automatic run_end(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            clk1();
            if (done || pass || fail) begin lat = cyc; break; end
        end
        if (lat < 0) check("end_budget", 0, 1);
    endtask

    task automatic press(input int colour, input int wait_n);
        repeat (wait_n) clk1();
        btn_valid = 1'b1; btn_color = 2'(colour);
        clk1();
        btn_valid = 1'b0;
    endtask

    int lat, len, err_at, found;

    initial begin
        clr_stats();
        do_reset();
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {done, pass, fail, lfsr_step, lfsr_rerun}, 0);

        // show, tick every cycle
        tick = 1'b1;
        start(1, 0, 2);
        check("show_busy", busy, 1);
        check("show_rerun_now", lfsr_rerun, 1);
        run_end(100, lat);
        check("show_latency", lat, 14);
        check("show_notes", notes.size(), 2);
        if (notes.size() == 2) begin
            check("show_note0", notes[0], 1);
            check("show_note1", notes[1], 0);
        end
        check("show_on_ticks", on_ticks, 2 * ON_T);
        check("show_steps", n_step, 2);
        check("show_reruns", n_rerun, 1);
        check("show_done", n_done, 1);
        check("show_busy_end", busy, 0);
        check("show_lfsr", lfsr, 16'hAB38);
        check("show_proto", n_bad, 0);

        // check pass
        tick = 1'b0;
        start(0, 1, 2);
        press(1, 3);
        check("chk_mid_pass", pass, 0);
        press(0, 4);
        check("chk_pass", pass, 1);
        check("chk_nofail", n_fail, 0);
        check("chk_steps", n_step, 2);

        // mismatch on first press
        start(0, 1, 2);
        press(3, 3);
        check("mis_fail", fail, 1);
        check("mis_steps", n_step, 0);
        check("mis_busy", busy, 0);

        // timeout at the 20th tick
        tick = 1'b1;
        start(0, 1, 1);
        run_end(60, lat);
        check("to_latency", lat, 23);
        check("to_fail", n_fail, 1);
        start(0, 1, 1);
        while (cyc < 22) clk1();
        btn_valid = 1'b1; btn_color = 2'(colour_at(0)); clk1(); btn_valid = 1'b0;
        check("to_press_pass", pass, 1);
        check("to_press_nofail", n_fail, 0);

        // length 0 show
        start(1, 0, 0);
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        repeat (3) clk1();
        check("len0_lfsr", n_step + n_rerun, 0);
        check("len0_once", n_done, 1);

        // both starts: show wins
        start(1, 1, 1);
        run_end(60, lat);
        check("both_notes", notes.size(), 1);
        check("both_done", n_done, 1);
        check("both_nopass", n_pass, 0);

        // start while busy is ignored
        start(1, 0, 2);
        repeat (3) clk1();
        start_show = 1'b1; length = LEN_W'(5); clk1(); start_show = 1'b0;
        run_end(100, lat);
        check("busy_notes", notes.size(), 2);
        check("busy_steps", n_step, 2);
        repeat (3) clk1();
        check("busy_done", n_done, 1);

        // reset while the first note is lit
        start(1, 0, 2);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            clk1();
            if (led == 4'b0010) found = 1;
        end
        check("rst_on_found", found, 1);
        reset = 1'b1; clk1(); reset = 1'b0;
        check("rst_on_led", led, 0);
        check("rst_on_busy", busy, 0);
        repeat (20) clk1();
        check("rst_on_nodone", n_done, 0);
        start(1, 0, 2);
        run_end(100, lat);
        check("replay_len", notes.size(), 2);
        if (notes.size() == 2) begin
            check("replay_note0", notes[0], 1);
            check("replay_note1", notes[1], 0);
        end

        // randomized runs against the note-level model
        rand_tick = 1;
        for (int it = 0; it < 24; it++) begin
            seed = 16'($urandom_range(1, 65535));
            len = $urandom_range(1, 5);
            if ($urandom_range(0, 1) == 0) begin
                start(1, 0, len);
                run_end(400, lat);
                check("r_show_len", notes.size(), len);
                for (int k = 0; k < notes.size() && k < len; k++)
                    check("r_show_note", notes[k], colour_at(k));
                check("r_show_ticks", on_ticks, ON_T * len);
                check("r_show_steps", n_step, STEPS * (len - 1));
                check("r_show_done", n_done, 1);
            end else begin
                err_at = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, len - 1)) : len;
                start(0, 1, len);
                for (int k = 0; k < len && k <= err_at; k++) begin
                    if (k == err_at)
                        press(colour_at(k) ^ int'($urandom_range(1, 3)), $urandom_range(3, 7));
                    else
                        press(colour_at(k), $urandom_range(3, 7));
                end
                if (err_at < len) begin
                    check("r_chk_fail", fail, 1);
                    check("r_chk_steps", n_step, STEPS * err_at);
                end else begin
                    check("r_chk_pass", pass, 1);
                    check("r_chk_steps", n_step, STEPS * (len - 1));
                end
                check("r_chk_once", n_pass + n_fail, 1);
            end
            check("r_proto", n_bad, 0);
            repeat (2) clk1();
        end

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
